// File: rtl/rom_loader_if.sv
// ROM-load bundle. It carries the initiator handshake, the ROM write port and
// the session status signals. The loader uses the slave modport. The initiator
// side (host bridge or test driver) uses the master modport.
interface rom_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
);
  // Initiator handshake
  logic                  rom_loader_reset;
  logic                  rom_loader_load;
  logic [DATA_WIDTH-1:0] rom_loader_data;
  logic                  rom_loader_load_received;
  logic                  rom_loader_ack;

  // ROM write port
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;

  // Session status
  logic                  loading;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  overflow;

  modport slave (
    input  rom_loader_reset, rom_loader_load, rom_loader_data, mem_ready,
    output rom_loader_load_received, rom_loader_ack,
    output mem_we, mem_addr, mem_wdata,
    output loading, word_count, overflow
  );

  modport master (
    output rom_loader_reset, rom_loader_load, rom_loader_data, mem_ready,
    input  rom_loader_load_received, rom_loader_ack,
    input  mem_we, mem_addr, mem_wdata,
    input  loading, word_count, overflow
  );
endinterface

// File: rtl/rom_loader.sv
// ROM loader. It receives instruction words one at a time over the
// load / load_received / ack handshake and writes them to consecutive ROM
// addresses. The ROM port can stall the write with wait states. The loading
// flag holds the CPU in reset while a load session is in progress. All
// outputs come straight from registers.
module rom_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_WORDS  = 32768
) (
  input  logic         clk,
  input  logic         reset,
  rom_loader_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  localparam logic [ADDR_WIDTH:0] LP_MAX_WORDS = (ADDR_WIDTH+1)'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0] LP_ONE       = (ADDR_WIDTH+1)'(1);

  logic [0:0]            r_state;
  logic                  r_load_received;
  logic                  r_ack;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_loading;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_overflow;

  logic                  w_room;
  logic                  w_commit;

  // Words past capacity are still handshaken, but they never reach the ROM.
  assign w_room   = (r_word_count < LP_MAX_WORDS);
  assign w_commit = r_mem_we & bus.mem_ready;

  // Session control, handshake and ROM write sequencing.
  // NOTE: every register here uses <=. All of them update together on the
  // edge, so the IDLE/WRITE decisions see the values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_load_received <= 1'b0;
      r_ack           <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_loading       <= 1'b0;
      r_word_count    <= '0;
      r_overflow      <= 1'b0;
    end else if (bus.rom_loader_reset) begin
      // A new session starts. It wins over load on this edge and aborts any
      // write still in flight.
      r_state         <= S_IDLE;
      r_load_received <= 1'b0;
      r_ack           <= 1'b1;
      r_mem_we        <= 1'b0;
      r_loading       <= 1'b1;
      r_word_count    <= '0;
      r_overflow      <= 1'b0;
    end else begin
      r_load_received <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.rom_loader_load) begin
            r_mem_wdata     <= bus.rom_loader_data;
            r_mem_addr      <= r_word_count[ADDR_WIDTH-1:0];
            r_load_received <= 1'b1;
            r_ack           <= 1'b0;
            if (w_room) begin
              r_mem_we   <= 1'b1;
            end else begin
              r_overflow <= 1'b1;
            end
            r_state <= S_WRITE;
          end else begin
            // Load is low, so the session ends and the CPU is released.
            r_ack     <= 1'b1;
            r_loading <= 1'b0;
          end
        end
        S_WRITE: begin
          // Data is never sampled here. An initiator that holds load high
          // while it advances data cannot be captured twice.
          if (r_mem_we) begin
            if (w_commit) begin
              r_mem_we     <= 1'b0;
              r_word_count <= r_word_count + LP_ONE;
              r_ack        <= 1'b1;
              r_state      <= S_IDLE;
            end
          end else begin
            // The word was discarded for lack of room. Nothing to commit.
            r_ack   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_loader_load_received = r_load_received;
  assign bus.rom_loader_ack           = r_ack;
  assign bus.mem_we                   = r_mem_we;
  assign bus.mem_addr                 = r_mem_addr;
  assign bus.mem_wdata                = r_mem_wdata;
  assign bus.loading                  = r_loading;
  assign bus.word_count               = r_word_count;
  assign bus.overflow                 = r_overflow;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader. It instantiates a small-capacity loader (MAX_WORDS=4)
// so the overflow path is reachable. It applies a cycle table of
// reset/start/capture vectors, then hand-written corner sequences, then
// random sessions. The random sessions are scored against a word-level model:
// the words sent, the writes they should produce and the final session status.
module tb_rom_loader;

  localparam int DW   = 16;
  localparam int AW   = 15;
  localparam int MAXW = 4;

  logic clk;
  logic reset;

  rom_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rom_loader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_WORDS  (MAXW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Writes the ROM actually accepted: address, data and cycle stamp.
  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  int            obs_cyc[$];

  // Words the initiator sends in the current session.
  logic [DW-1:0] sess_words[$];

  typedef struct {
    logic          rst;
    logic          rlr;
    logic          ld;
    logic [DW-1:0] d;
    logic          rdy;
    logic          e_lr;
    logic          e_ack;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_loading;
    logic [AW:0]   e_wc;
    logic          e_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock. Inputs are already set. Log a write if the ROM will
  // accept one on this edge. Return at the following falling edge.
  task automatic step();
    if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1 && !reset && !bus.rom_loader_reset) begin
      obs_addr.push_back(bus.mem_addr);
      obs_data.push_back(bus.mem_wdata);
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_session();
    bus.rom_loader_reset = 1'b1;
    bus.rom_loader_load  = 1'b0;
    bus.mem_ready        = 1'b1;
    step();
    bus.rom_loader_reset = 1'b0;
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  // Run a full session from sess_words against the word-level model.
  task automatic run_session(input string tag, input int rdy_pct);
    int n;
    int idx;
    int budget;
    int n_wr;
    n   = sess_words.size();
    idx = 0;
    n_wr = (n < MAXW) ? n : MAXW;
    start_session();
    check({tag, ".start_loading"}, 32'(bus.loading), 32'd1);
    check({tag, ".start_wc"}, 32'(bus.word_count), 32'd0);
    if (n > 0) begin
      bus.rom_loader_load = 1'b1;
      bus.rom_loader_data = sess_words[0];
    end
    budget = 0;
    while (idx < n && budget < 400) begin
      bus.mem_ready = ($urandom_range(99) < rdy_pct);
      step();
      budget++;
      if (bus.rom_loader_load_received) begin
        idx++;
        check({tag, ".ovf_at_capture"}, 32'(bus.overflow), 32'(idx > MAXW));
        check({tag, ".we_at_capture"}, 32'(bus.mem_we), 32'(idx <= MAXW));
        check({tag, ".ack_at_capture"}, 32'(bus.rom_loader_ack), 32'd0);
        check({tag, ".loading_held"}, 32'(bus.loading), 32'd1);
        if (idx <= MAXW) begin
          check({tag, ".addr_at_capture"}, 32'(bus.mem_addr), 32'(idx - 1));
          check({tag, ".wdata_at_capture"}, 32'(bus.mem_wdata), 32'(sess_words[idx-1]));
        end
        if (idx < n) bus.rom_loader_data = sess_words[idx];
        else         bus.rom_loader_load = 1'b0;
      end
    end
    check({tag, ".captured"}, 32'(idx), 32'(n));
    bus.rom_loader_load = 1'b0;
    budget = 0;
    while (bus.rom_loader_ack !== 1'b1 && budget < 400) begin
      bus.mem_ready = ($urandom_range(99) < rdy_pct);
      step();
      budget++;
    end
    check({tag, ".ack_end"}, 32'(bus.rom_loader_ack), 32'd1);
    step();
    check({tag, ".loading_end"}, 32'(bus.loading), 32'd0);
    check({tag, ".wc_end"}, 32'(bus.word_count), 32'(n_wr));
    check({tag, ".ovf_end"}, 32'(bus.overflow), 32'(n > MAXW));
    check({tag, ".n_writes"}, 32'(obs_addr.size()), 32'(n_wr));
    for (int i = 0; i < obs_addr.size() && i < n_wr; i++) begin
      check({tag, ".wr_addr"}, 32'(obs_addr[i]), 32'(i));
      check({tag, ".wr_data"}, 32'(obs_data[i]), 32'(sess_words[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fields: rst rlr ld data rdy | lr ack we addr wdata loading wc ovf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 16'h0000, 1'b0, 16'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 16'h0000, 1'b0, 16'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 15'd0, 16'h0000, 1'b0, 16'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b0, 15'd0, 16'h0000, 1'b1, 16'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b1, 15'd0, 16'h1111, 1'b1, 16'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 15'd0, 16'h1111, 1'b1, 16'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b0, 1'b1, 15'd1, 16'h2222, 1'b1, 16'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 15'd1, 16'h2222, 1'b1, 16'd1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 15'd1, 16'h2222, 1'b1, 16'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 15'd1, 16'h2222, 1'b0, 16'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 15'd1, 16'h2222, 1'b1, 16'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 15'd1, 16'h2222, 1'b0, 16'd0, 1'b0};

    bus.rom_loader_reset = 1'b0;
    bus.rom_loader_load  = 1'b0;
    bus.rom_loader_data  = '0;
    bus.mem_ready        = 1'b1;
    reset                = 1'b1;

    // Cycle table: reset, start with load on the same edge, capture, stall.
    for (int i = 0; i < 12; i++) begin
      reset                = vecs[i].rst;
      bus.rom_loader_reset = vecs[i].rlr;
      bus.rom_loader_load  = vecs[i].ld;
      bus.rom_loader_data  = vecs[i].d;
      bus.mem_ready        = vecs[i].rdy;
      step();
      check($sformatf("v%0d.load_received", i), 32'(bus.rom_loader_load_received), 32'(vecs[i].e_lr));
      check($sformatf("v%0d.ack", i),           32'(bus.rom_loader_ack),           32'(vecs[i].e_ack));
      check($sformatf("v%0d.mem_we", i),        32'(bus.mem_we),                   32'(vecs[i].e_we));
      check($sformatf("v%0d.mem_addr", i),      32'(bus.mem_addr),                 32'(vecs[i].e_addr));
      check($sformatf("v%0d.mem_wdata", i),     32'(bus.mem_wdata),                32'(vecs[i].e_wdata));
      check($sformatf("v%0d.loading", i),       32'(bus.loading),                  32'(vecs[i].e_loading));
      check($sformatf("v%0d.word_count", i),    32'(bus.word_count),               32'(vecs[i].e_wc));
      check($sformatf("v%0d.overflow", i),      32'(bus.overflow),                 32'(vecs[i].e_ovf));
    end

    // Four words with the ROM always ready: one commit every two cycles.
    sess_words = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF};
    run_session("four", 100);
    for (int i = 1; i < obs_cyc.size(); i++)
      check("four.turnaround", 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd2);

    // A three-cycle ROM stall holds the write port. Load stays high, so no
    // recapture can happen while in WRITE.
    begin
      int lr_seen;
      start_session();
      bus.rom_loader_load = 1'b1;
      bus.rom_loader_data = 16'h5A5A;
      step();
      lr_seen = int'(bus.rom_loader_load_received);
      check("stall.we0", 32'(bus.mem_we), 32'd1);
      for (int s = 0; s < 3; s++) begin
        bus.mem_ready = 1'b0;
        step();
        lr_seen += int'(bus.rom_loader_load_received);
        check("stall.we", 32'(bus.mem_we), 32'd1);
        check("stall.addr", 32'(bus.mem_addr), 32'd0);
        check("stall.data", 32'(bus.mem_wdata), 32'h5A5A);
        check("stall.ack", 32'(bus.rom_loader_ack), 32'd0);
      end
      bus.mem_ready       = 1'b1;
      bus.rom_loader_load = 1'b0;
      step();
      lr_seen += int'(bus.rom_loader_load_received);
      check("stall.we_done", 32'(bus.mem_we), 32'd0);
      check("stall.ack_done", 32'(bus.rom_loader_ack), 32'd1);
      check("stall.wc", 32'(bus.word_count), 32'd1);
      check("stall.lr_pulses", 32'(lr_seen), 32'd1);
      check("stall.n_writes", 32'(obs_addr.size()), 32'd1);
    end

    // A session restart during a stalled write aborts the write.
    start_session();
    bus.rom_loader_load = 1'b1;
    bus.rom_loader_data = 16'h0BAD;
    bus.mem_ready       = 1'b0;
    step();
    check("abort.capture", 32'(bus.rom_loader_load_received), 32'd1);
    bus.rom_loader_load = 1'b0;
    step();
    step();
    check("abort.stalled", 32'(bus.mem_we), 32'd1);
    bus.rom_loader_reset = 1'b1;
    step();
    bus.rom_loader_reset = 1'b0;
    check("abort.we", 32'(bus.mem_we), 32'd0);
    check("abort.wc", 32'(bus.word_count), 32'd0);
    check("abort.ack", 32'(bus.rom_loader_ack), 32'd1);
    check("abort.loading", 32'(bus.loading), 32'd1);
    check("abort.no_write", 32'(obs_addr.size()), 32'd0);
    bus.rom_loader_load = 1'b1;
    bus.rom_loader_data = 16'h7777;
    bus.mem_ready       = 1'b1;
    step();
    check("abort.recapture", 32'(bus.rom_loader_load_received), 32'd1);
    check("abort.addr", 32'(bus.mem_addr), 32'd0);
    bus.rom_loader_load = 1'b0;
    step();
    check("abort.n_writes", 32'(obs_addr.size()), 32'd1);
    if (obs_addr.size() > 0) begin
      check("abort.wr_addr", 32'(obs_addr[0]), 32'd0);
      check("abort.wr_data", 32'(obs_data[0]), 32'h7777);
    end
    check("abort.wc_after", 32'(bus.word_count), 32'd1);

    // Six words into a four-word ROM: the last two are handshaken and dropped.
    sess_words = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    run_session("ovf", 100);

    // Global reset in the middle of a stalled write.
    start_session();
    bus.rom_loader_load = 1'b1;
    bus.rom_loader_data = 16'h4321;
    bus.mem_ready       = 1'b0;
    step();
    bus.rom_loader_load = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("rst.lr", 32'(bus.rom_loader_load_received), 32'd0);
    check("rst.ack", 32'(bus.rom_loader_ack), 32'd0);
    check("rst.we", 32'(bus.mem_we), 32'd0);
    check("rst.addr", 32'(bus.mem_addr), 32'd0);
    check("rst.wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst.loading", 32'(bus.loading), 32'd0);
    check("rst.wc", 32'(bus.word_count), 32'd0);
    check("rst.ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    check("rst.ack_after", 32'(bus.rom_loader_ack), 32'd1);
    check("rst.no_write", 32'(obs_addr.size()), 32'd0);

    // Random sessions: random lengths (including past capacity), random
    // data and random ROM wait states.
    for (int k = 0; k < 20; k++) begin
      int n;
      int pct;
      n   = int'($urandom_range(7));
      pct = int'($urandom_range(100, 30));
      sess_words.delete();
      for (int j = 0; j < n; j++) sess_words.push_back(DW'($urandom));
      run_session($sformatf("rnd%0d", k), pct);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
